// File: rtl/fetch_sequencer_pkg.sv
// Core-wide definitions shared by the fetch sequencer, decoder and datapath:
// opcodes, instruction field positions and the fetch FSM encoding.
package fetch_sequencer_pkg;

  localparam int unsigned InstrW = 16;

  localparam logic [3:0] OpRtype = 4'h0;
  localparam logic [3:0] OpAddi  = 4'h1;
  localparam logic [3:0] OpAndi  = 4'h2;
  localparam logic [3:0] OpOri   = 4'h3;
  localparam logic [3:0] OpNori  = 4'h4;
  localparam logic [3:0] OpBeq   = 4'h5;
  localparam logic [3:0] OpBne   = 4'h6;
  localparam logic [3:0] OpSlti  = 4'h7;
  localparam logic [3:0] OpLw    = 4'h8;
  localparam logic [3:0] OpSw    = 4'h9;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RsMsb     = 11;
  localparam int unsigned RsLsb     = 9;
  localparam int unsigned RtMsb     = 8;
  localparam int unsigned RtLsb     = 6;
  localparam int unsigned ImmMsb    = 5;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StExec   = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

  function automatic logic [3:0] get_opcode(input logic [InstrW-1:0] word);
    return word[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential PC+1 or PC+1+sext(imm6) when a
// BEQ/BNE condition holds. All arithmetic wraps modulo 2^PC_W.
module next_pc_calc #(
  parameter int unsigned PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [5:0]      imm6,
  input  logic            branch,
  input  logic            bneq,
  input  logic            alu_zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] tgt_pc;
  logic            take;

  always_comb begin
    seq_pc  = pc + PC_W'(1);
    offset  = PC_W'(signed'(imm6));
    tgt_pc  = seq_pc + offset;
    // Both flags high is illegal upstream; the OR is applied as-is regardless.
    take    = (branch & alu_zero) | (bneq & ~alu_zero);
    next_pc = take ? tgt_pc : seq_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencing stage: fetches over a req/ack handshake,
// presents each instruction for one EXEC cycle, then picks the next PC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [InstrW-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [InstrW-1:0] instr,
  output logic              instr_valid,
  output logic [PC_W-1:0]   pc,
  input  logic              branch,
  input  logic              bneq,
  input  logic              alu_zero,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   next_pc;

  next_pc_calc #(
    .PC_W(PC_W)
  ) u_next_pc_calc (
    .pc      (pc_q),
    .imm6    (instr_q[ImmMsb:ImmLsb]),
    .branch  (branch),
    .bneq    (bneq),
    .alu_zero(alu_zero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (get_opcode(instr_q) == OpHalt) begin
          state_d = StHalted;
        end else begin
          pc_d    = next_pc;
          state_d = StFetch;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StExec);
  assign halted      = (state_q == StHalted);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model, decoder stand-in and a
// scoreboard of fetched words checked when the DUT presents them in EXEC.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  addr;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        branch;
  logic        bneq;
  logic        alu_zero;
  logic        halted;

  logic [7:0]  t_pc;
  logic [5:0]  t_imm;
  logic        t_br, t_bn, t_z;
  logic [7:0]  t_next;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_exec_cyc = 0;
  bit          have_last = 0;
  logic [7:0]  model_pc;
  logic [15:0] last_instr;
  logic [15:0] mem [256];
  logic [31:0] zero_plan;
  sb_t         sb_q[$];
  int          plan [29] = '{0, 1, 2, 3, 4, 5, 4, 5, 6, 10, 11, 10, 14, 254, 255,
                             0, 1, 2, 3, 4, 5, 6, 10, 14, 254, 4, 5, 6, 7};

  fetch_sequencer #(
    .PC_W    (8),
    .RESET_PC(8'd0)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .branch     (branch),
    .bneq       (bneq),
    .alu_zero   (alu_zero),
    .halted     (halted)
  );

  next_pc_calc #(
    .PC_W(8)
  ) u_npc (
    .pc      (t_pc),
    .imm6    (t_imm),
    .branch  (t_br),
    .bneq    (t_bn),
    .alu_zero(t_z),
    .next_pc (t_next)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [5:0] imm);
    return {op, 3'd1, 3'd2, imm};
  endfunction

  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [5:0] imm,
                                          input logic br, input logic bn, input logic z);
    int  off;
    int  s;
    logic take;
    off  = imm[5] ? int'(imm) - 64 : int'(imm);
    take = (br & z) | (bn & ~z);
    s    = int'(p) + 1 + (take ? off : 0);
    return 8'(s & 255);
  endfunction

  // Entered with the DUT in its first FETCH cycle; returns after the EXEC cycle.
  task automatic run_instr(input int step, input int wait_n, input bit stray, input logic z);
    sb_t        e;
    logic [3:0] op;
    check_eq("fetch_req", imem_req, 1);
    check_eq("fetch_addr", imem_addr, model_pc);
    check_eq("path_addr", imem_addr, plan[step]);
    check_eq("fetch_valid_lo", instr_valid, 0);
    for (int w = 0; w < wait_n; w++) begin
      imem_ack = 1'b0;
      tick();
      check_eq("wait_req", imem_req, 1);
      check_eq("wait_addr", imem_addr, model_pc);
      check_eq("wait_valid_lo", instr_valid, 0);
      check_eq("wait_instr_hold", instr, last_instr);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem[model_pc];
    sb_q.push_back('{word: mem[model_pc], addr: model_pc});
    tick();
    // Stray acks while in EXEC must not disturb instr.
    imem_ack   = stray;
    imem_rdata = 16'hDEAD;
    check_eq("exec_valid", instr_valid, 1);
    check_eq("exec_req_lo", imem_req, 0);
    check_eq("sb_depth", sb_q.size(), 1);
    e = '0;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check_eq("exec_instr", instr, e.word);
    check_eq("exec_pc", pc, e.addr);
    if (have_last) check_eq("issue_period", cyc - last_exec_cyc, 2 + wait_n);
    last_exec_cyc = cyc;
    have_last     = 1;
    op       = e.word[15:12];
    branch   = (op == 4'h5);
    bneq     = (op == 4'h6);
    alu_zero = z;
    if (op != 4'hF) model_pc = ref_next(e.addr, e.word[5:0], branch, bneq, z);
    last_instr = e.word;
    tick();
    imem_ack = 1'b0;
    branch   = 1'b0;
    bneq     = 1'b0;
    alu_zero = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    branch     = 1'b0;
    bneq       = 1'b0;
    alu_zero   = 1'b0;
    t_pc = '0; t_imm = '0; t_br = 1'b0; t_bn = 1'b0; t_z = 1'b0;
    zero_plan  = 32'h0980_1620;
    for (int a = 0; a < 256; a++) mem[a] = enc(4'h1, 6'd1);
    mem[5]   = enc(4'h5, 6'h3E);
    mem[6]   = enc(4'h6, 6'd3);
    mem[7]   = enc(4'hF, 6'd0);
    mem[10]  = enc(4'h6, 6'd3);
    mem[11]  = enc(4'h5, 6'h3E);
    mem[14]  = enc(4'h5, 6'h2F);
    mem[254] = enc(4'h5, 6'd5);

    tick();
    check_eq("rst_pc", pc, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_halted", halted, 0);
    reset = 1'b0;
    tick();
    model_pc   = 8'd0;
    last_instr = 16'h0000;

    for (int s = 0; s < 29; s++) begin
      run_instr(s, (s == 2) ? 4 : ((s == 17) ? 1 : 0), (s % 2) == 1, zero_plan[s]);
    end

    for (int k = 0; k < 4; k++) begin
      check_eq("halt_flag", halted, 1);
      check_eq("halt_req_lo", imem_req, 0);
      check_eq("halt_valid_lo", instr_valid, 0);
      check_eq("halt_pc", pc, 7);
      check_eq("halt_instr", instr, mem[7]);
      imem_ack   = 1'b1;
      imem_rdata = 16'h1234;
      tick();
    end
    imem_ack = 1'b0;

    // Reset while a fetch is pending, with an ack arriving on the same edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_eq("refetch_req", imem_req, 1);
    tick();
    tick();
    check_eq("pend_req", imem_req, 1);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    check_eq("mid_rst_req", imem_req, 0);
    check_eq("mid_rst_pc", pc, 0);
    check_eq("mid_rst_instr", instr, 0);
    check_eq("mid_rst_valid", instr_valid, 0);
    check_eq("mid_rst_halted", halted, 0);
    reset = 1'b0;
    tick();
    check_eq("idle_ack_ignored", instr, 0);
    imem_ack   = 1'b0;
    model_pc   = 8'd0;
    last_instr = 16'h0000;
    have_last  = 0;
    for (int s = 0; s < 3; s++) run_instr(s, 0, 1'b0, 1'b0);

    // Standalone next-PC block: fixed corners, then random vectors.
    t_pc = 8'd5;   t_imm = 6'h3E; t_br = 1; t_bn = 0; t_z = 1; #1;
    check_eq("npc_beq_back", t_next, 4);
    t_pc = 8'd255; t_imm = 6'd9;  t_br = 0; t_bn = 0; t_z = 1; #1;
    check_eq("npc_wrap", t_next, 0);
    t_pc = 8'd3;   t_imm = 6'h20; t_br = 1; t_bn = 1; t_z = 0; #1;
    check_eq("npc_both_flags", t_next, 8'd228);
    for (int i = 0; i < 24; i++) begin
      t_pc  = 8'($urandom_range(0, 255));
      t_imm = 6'($urandom_range(0, 63));
      t_br  = 1'($urandom_range(0, 1));
      t_bn  = 1'($urandom_range(0, 1));
      t_z   = 1'($urandom_range(0, 1));
      #1;
      check_eq("npc_rand", t_next, ref_next(t_pc, t_imm, t_br, t_bn, t_z));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
